// File: rtl/dma_desc_sched_pkg.sv
`default_nettype none
// ==========================================================================
// dma_desc_sched_pkg : descriptor, state and error types for the scheduler
// Revision 1.0
// ==========================================================================
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 512
`endif

package dma_desc_sched_pkg;

  localparam int DMA_BEAT_BYTES = `DMA_DATA_WIDTH / 8;
  localparam int DMA_BEAT_LSB   = $clog2(DMA_BEAT_BYTES);

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [31:0] num_bytes;
  } s_dma_desc_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } dma_sched_st_t;

  typedef enum logic [1:0] {
    DMA_ERR_NONE  = 2'd0,
    DMA_ERR_DESC  = 2'd1,
    DMA_ERR_ABORT = 2'd2
  } dma_err_t;

  // Streamers move whole beats only, so length and both addresses must be beat aligned.
  function automatic logic desc_valid(input s_dma_desc_t d);
    return (d.num_bytes != '0) &&
           (d.num_bytes[DMA_BEAT_LSB-1:0] == '0) &&
           (d.src_addr[DMA_BEAT_LSB-1:0] == '0) &&
           (d.dst_addr[DMA_BEAT_LSB-1:0] == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_desc_sched.sv
`default_nettype none
// ==========================================================================
// dma_desc_sched : walks CSR descriptor slots and launches rd/wr streamers
// Revision 1.0
// ==========================================================================
module dma_desc_sched
  import dma_desc_sched_pkg::*;
#(
  parameter  int NUM_DESC = 4,
  localparam int DIDX_W   = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dma_go_i,
  input  logic                dma_abort_i,
  input  logic [NUM_DESC-1:0] dma_desc_en_i,
  input  s_dma_desc_t         dma_desc_i [NUM_DESC],
  output s_dma_desc_t         dma_desc_o,
  output logic                dma_rd_stream_valid_o,
  input  logic                dma_rd_stream_done_i,
  output logic                dma_wr_stream_valid_o,
  input  logic                dma_wr_stream_done_i,
  output logic                dma_busy_o,
  output logic                dma_done_o,
  output dma_err_t            dma_err_o,
  output logic [DIDX_W-1:0]   dma_cur_desc_o
);

  localparam logic [DIDX_W-1:0] LAST_IDX = DIDX_W'(NUM_DESC - 1);

  dma_sched_st_t     state_q, state_d;
  logic [DIDX_W-1:0] idx_q, idx_d;
  s_dma_desc_t       desc_q, desc_d;
  dma_err_t          err_q, err_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_valid_q, wr_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_flag_q, rd_flag_d;
  logic              wr_flag_q, wr_flag_d;
  logic              abort_pend_q, abort_pend_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    desc_d       = desc_q;
    err_d        = err_q;
    rd_valid_d   = 1'b0;
    wr_valid_d   = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_flag_d    = rd_flag_q;
    wr_flag_d    = wr_flag_q;
    abort_pend_d = abort_pend_q;

    if (dma_abort_i && (state_q == SCAN || state_q == LAUNCH || state_q == WAIT)) begin
      abort_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (dma_go_i) begin
          err_d        = DMA_ERR_NONE;
          idx_d        = '0;
          abort_pend_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (abort_pend_d) begin
          err_d   = DMA_ERR_ABORT;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (dma_desc_en_i[idx_q]) begin
          if (desc_valid(dma_desc_i[idx_q])) begin
            desc_d     = dma_desc_i[idx_q];
            rd_valid_d = 1'b1;
            wr_valid_d = 1'b1;
            state_d    = LAUNCH;
          end else begin
            err_d   = DMA_ERR_DESC;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LAUNCH: begin
        rd_flag_d = 1'b0;
        wr_flag_d = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        rd_flag_d = rd_flag_q | dma_rd_stream_done_i;
        wr_flag_d = wr_flag_q | dma_wr_stream_done_i;
        if (rd_flag_d && wr_flag_d) begin
          // Last slot finishes straight into DONE so it is never rescanned.
          if (idx_q == LAST_IDX) begin
            if (abort_pend_d) err_d = DMA_ERR_ABORT;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      desc_q       <= '0;
      err_q        <= DMA_ERR_NONE;
      rd_valid_q   <= 1'b0;
      wr_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_flag_q    <= 1'b0;
      wr_flag_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      desc_q       <= desc_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      wr_valid_q   <= wr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_flag_q    <= rd_flag_d;
      wr_flag_q    <= wr_flag_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign dma_desc_o            = desc_q;
  assign dma_rd_stream_valid_o = rd_valid_q;
  assign dma_wr_stream_valid_o = wr_valid_q;
  assign dma_busy_o            = busy_q;
  assign dma_done_o            = done_q;
  assign dma_err_o             = err_q;
  assign dma_cur_desc_o        = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_desc_sched.sv
`default_nettype none
// ==========================================================================
// tb_dma_desc_sched : scoreboard bench with behavioural rd/wr streamer responders
// Revision 1.0
// ==========================================================================
module tb_dma_desc_sched;
  import dma_desc_sched_pkg::*;

  localparam int NUM_DESC = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                dma_go_i = 1'b0;
  logic                dma_abort_i = 1'b0;
  logic [NUM_DESC-1:0] dma_desc_en_i = '0;
  s_dma_desc_t         desc [NUM_DESC];
  s_dma_desc_t         dma_desc_o;
  logic                dma_rd_stream_valid_o;
  logic                dma_rd_stream_done_i = 1'b0;
  logic                dma_wr_stream_valid_o;
  logic                dma_wr_stream_done_i = 1'b0;
  logic                dma_busy_o;
  logic                dma_done_o;
  dma_err_t            dma_err_o;
  logic [1:0]          dma_cur_desc_o;

  dma_desc_sched #(.NUM_DESC(NUM_DESC)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .dma_go_i              (dma_go_i),
    .dma_abort_i           (dma_abort_i),
    .dma_desc_en_i         (dma_desc_en_i),
    .dma_desc_i            (desc),
    .dma_desc_o            (dma_desc_o),
    .dma_rd_stream_valid_o (dma_rd_stream_valid_o),
    .dma_rd_stream_done_i  (dma_rd_stream_done_i),
    .dma_wr_stream_valid_o (dma_wr_stream_valid_o),
    .dma_wr_stream_done_i  (dma_wr_stream_done_i),
    .dma_busy_o            (dma_busy_o),
    .dma_done_o            (dma_done_o),
    .dma_err_o             (dma_err_o),
    .dma_cur_desc_o        (dma_cur_desc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [1:0]  idx;
    s_dma_desc_t d;
  } launch_t;

  typedef struct {
    logic [1:0]  idx;
    s_dma_desc_t d;
  } exp_t;

  launch_t  obs_q [$];
  exp_t     exp_q [$];
  int       errors = 0;
  int       checks = 0;
  int       done_t;
  dma_err_t err_at_done;
  logic     busy_at_done;
  int       unstable;
  int       pair_bad;
  bit       timed_out;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int i, input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    desc[i].src_addr  = s;
    desc[i].dst_addr  = d;
    desc[i].num_bytes = n;
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx = 2'(i);
    e.d   = desc[i];
    exp_q.push_back(e);
  endtask

  // Issues go, then plays both streamers: each done pulse lands a fixed latency after launch.
  // t counts cycles from the go cycle (t=0).
  task automatic run_op(input int rd_lat, input int wr_lat, input int abort_lat, input bit abort_with_go);
    int t = 0;
    int rd_due = -1;
    int wr_due = -1;
    int abort_due = -1;
    int hold_until = -1;
    bit launched = 0;
    s_dma_desc_t held = '0;
    launch_t l;
    obs_q.delete();
    done_t = -1; unstable = 0; pair_bad = 0; timed_out = 0;
    dma_go_i = 1'b1;
    dma_abort_i = abort_with_go;
    while (done_t < 0 && !timed_out) begin
      step();
      t++;
      dma_go_i = 1'b0; dma_abort_i = 1'b0;
      dma_rd_stream_done_i = 1'b0; dma_wr_stream_done_i = 1'b0;
      if (dma_rd_stream_valid_o !== dma_wr_stream_valid_o) pair_bad++;
      if (dma_rd_stream_valid_o === 1'b1) begin
        l.t = t; l.idx = dma_cur_desc_o; l.d = dma_desc_o;
        obs_q.push_back(l);
        held = dma_desc_o;
        rd_due = t + rd_lat;
        wr_due = t + wr_lat;
        hold_until = (rd_due > wr_due) ? rd_due : wr_due;
        if (!launched && abort_lat >= 0) abort_due = t + abort_lat;
        launched = 1;
      end
      if (t <= hold_until && dma_desc_o !== held) unstable++;
      if (t == rd_due) dma_rd_stream_done_i = 1'b1;
      if (t == wr_due) dma_wr_stream_done_i = 1'b1;
      if (t == abort_due) dma_abort_i = 1'b1;
      if (dma_done_o === 1'b1) begin
        done_t = t; err_at_done = dma_err_o; busy_at_done = dma_busy_o;
      end
      if (t > 300) timed_out = 1;
    end
    dma_go_i = 1'b0; dma_abort_i = 1'b0;
    dma_rd_stream_done_i = 1'b0; dma_wr_stream_done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (dma_rd_stream_valid_o !== 1'b0 || dma_wr_stream_valid_o !== 1'b0 || dma_busy_o !== 1'b0 || dma_done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rv=%b wv=%b busy=%b done=%b exp all 0", dma_rd_stream_valid_o, dma_wr_stream_valid_o, dma_busy_o, dma_done_o);
    end
    checks++;
    if (dma_err_o !== DMA_ERR_NONE || dma_cur_desc_o !== 2'd0 || dma_desc_o !== '0) begin
      errors++;
      $display("FAIL reset_data got err=%0d cur=%0d desc=%h exp 0", dma_err_o, dma_cur_desc_o, dma_desc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    exp_t e; launch_t o;
    dma_desc_en_i = 4'b0001;
    push_exp(0);
    run_op(10, 14, -1, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL single timeout got no done exp done"); end
    checks++;
    if (obs_q.size() != 1 || obs_q[0].t != 2) begin
      errors++;
      $display("FAIL single launch got n=%0d t=%0d exp n=1 t=2", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].t : -1);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.d !== e.d) begin
        errors++;
        $display("FAIL single sb got idx=%0d desc=%h exp idx=%0d desc=%h", o.idx, o.d, e.idx, e.d);
      end
    end
    exp_q.delete();
    checks++;
    if (done_t != 20 || err_at_done !== DMA_ERR_NONE || busy_at_done !== 1'b1 || pair_bad != 0) begin
      errors++;
      $display("FAIL single done got t=%0d err=%0d busy=%b pair_bad=%0d exp t=20 err=0 busy=1 pair_bad=0", done_t, err_at_done, busy_at_done, pair_bad);
    end
    step();
    checks++;
    if (dma_busy_o !== 1'b0 || dma_done_o !== 1'b0) begin
      errors++;
      $display("FAIL single after got busy=%b done=%b exp 0 0", dma_busy_o, dma_done_o);
    end
  endtask

  task automatic test_two_slots();
    exp_t e; launch_t o;
    dma_desc_en_i = 4'b1010;
    push_exp(1);
    push_exp(3);
    run_op(3, 5, -1, 0);
    checks++;
    if (timed_out || obs_q.size() != 2) begin
      errors++;
      $display("FAIL two_slots count got n=%0d to=%0b exp n=2", obs_q.size(), timed_out);
    end else begin
      checks++;
      if (obs_q[0].t != 3 || obs_q[1].t != 11) begin
        errors++;
        $display("FAIL two_slots times got %0d,%0d exp 3,11", obs_q[0].t, obs_q[1].t);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.d !== e.d) begin
        errors++;
        $display("FAIL two_slots sb got idx=%0d desc=%h exp idx=%0d desc=%h", o.idx, o.d, e.idx, e.d);
      end
    end
    exp_q.delete();
    checks++;
    if (unstable != 0 || done_t != 17 || err_at_done !== DMA_ERR_NONE) begin
      errors++;
      $display("FAIL two_slots end got unstable=%0d t=%0d err=%0d exp 0 17 0", unstable, done_t, err_at_done);
    end
  endtask

  task automatic test_done_order();
    int lat_rd [2] = '{4, 6};
    int lat_wr [2] = '{4, 2};
    int exp_t2 [2] = '{8, 10};
    int exp_dn [2] = '{15, 19};
    exp_t e; launch_t o;
    dma_desc_en_i = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      dma_rd_stream_done_i = 1'b1; dma_wr_stream_done_i = 1'b1;
      step(); step();
      dma_rd_stream_done_i = 1'b0; dma_wr_stream_done_i = 1'b0;
      checks++;
      if (dma_busy_o !== 1'b0 || dma_rd_stream_valid_o !== 1'b0 || dma_done_o !== 1'b0) begin
        errors++;
        $display("FAIL stray_idle_done got busy=%b rv=%b done=%b exp 0", dma_busy_o, dma_rd_stream_valid_o, dma_done_o);
      end
      push_exp(0);
      push_exp(1);
      run_op(lat_rd[k], lat_wr[k], -1, 0);
      checks++;
      if (timed_out || obs_q.size() != 2 || done_t != exp_dn[k]) begin
        errors++;
        $display("FAIL order%0d run got n=%0d done_t=%0d exp n=2 done_t=%0d", k, obs_q.size(), done_t, exp_dn[k]);
      end else begin
        checks++;
        if (obs_q[1].t != exp_t2[k]) begin
          errors++;
          $display("FAIL order%0d second_launch got t=%0d exp t=%0d", k, obs_q[1].t, exp_t2[k]);
        end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o.idx !== e.idx || o.d !== e.d) begin
          errors++;
          $display("FAIL order%0d sb got idx=%0d exp idx=%0d", k, o.idx, e.idx);
        end
      end
      exp_q.delete();
      step();
    end
  endtask

  task automatic test_invalid();
    logic [31:0] bs [4] = '{32'h1000, 32'h1010, 32'h1000, 32'h1000};
    logic [31:0] bd [4] = '{32'h2000, 32'h2000, 32'h2000, 32'h2001};
    logic [31:0] bn [4] = '{32'h104,  32'h100,  32'h0,    32'h100};
    s_dma_desc_t keep;
    keep = desc[0];
    dma_desc_en_i = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_desc(0, bs[k], bd[k], bn[k]);
      run_op(1, 1, -1, 0);
      checks++;
      if (timed_out || obs_q.size() != 0 || err_at_done !== DMA_ERR_DESC || done_t != 2) begin
        errors++;
        $display("FAIL invalid%0d got launches=%0d err=%0d done_t=%0d exp 0 1 2", k, obs_q.size(), err_at_done, done_t);
      end
      step();
      checks++;
      if (dma_busy_o !== 1'b0 || dma_err_o !== DMA_ERR_DESC) begin
        errors++;
        $display("FAIL invalid%0d after got busy=%b err=%0d exp 0 1", k, dma_busy_o, dma_err_o);
      end
    end
    desc[0] = keep;
  endtask

  task automatic test_abort();
    exp_t e; launch_t o;
    dma_desc_en_i = 4'b1111;
    push_exp(0);
    run_op(8, 10, 3, 0);
    checks++;
    if (timed_out || obs_q.size() != 1 || err_at_done !== DMA_ERR_ABORT || done_t != 14) begin
      errors++;
      $display("FAIL abort_wait got launches=%0d err=%0d done_t=%0d exp 1 2 14", obs_q.size(), err_at_done, done_t);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.d !== e.d) begin
        errors++;
        $display("FAIL abort_wait sb got idx=%0d exp idx=%0d", o.idx, e.idx);
      end
    end
    exp_q.delete();
    step();
    dma_desc_en_i = 4'b0001;
    run_op(2, 2, -1, 1);
    checks++;
    if (timed_out || obs_q.size() != 1 || err_at_done !== DMA_ERR_NONE || done_t != 8) begin
      errors++;
      $display("FAIL abort_with_go got launches=%0d err=%0d done_t=%0d exp 1 0 8", obs_q.size(), err_at_done, done_t);
    end
    step();
  endtask

  task automatic test_async_reset();
    exp_t e; launch_t o;
    dma_desc_en_i = 4'b0010;
    dma_go_i = 1'b1;
    step();
    dma_go_i = 1'b0;
    step(); step(); step();
    checks++;
    if (dma_busy_o !== 1'b1 || dma_cur_desc_o !== 2'd1 || dma_desc_o !== desc[1]) begin
      errors++;
      $display("FAIL areset_pre got busy=%b cur=%0d desc=%h exp 1 1 %h", dma_busy_o, dma_cur_desc_o, dma_desc_o, desc[1]);
    end
    #2;
    rst_n = 1'b0;
    dma_rd_stream_done_i = 1'b0; dma_wr_stream_done_i = 1'b0;
    #1;
    checks++;
    if (dma_busy_o !== 1'b0 || dma_cur_desc_o !== 2'd0 || dma_desc_o !== '0 || dma_rd_stream_valid_o !== 1'b0 || dma_done_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_now got busy=%b cur=%0d desc=%h rv=%b done=%b exp all 0", dma_busy_o, dma_cur_desc_o, dma_desc_o, dma_rd_stream_valid_o, dma_done_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    dma_desc_en_i = 4'b0001;
    push_exp(0);
    run_op(3, 3, -1, 0);
    checks++;
    if (timed_out || obs_q.size() != 1 || done_t != 9 || obs_q[0].t != 2) begin
      errors++;
      $display("FAIL areset_rerun got launches=%0d done_t=%0d exp 1 9", obs_q.size(), done_t);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.idx !== e.idx || o.d !== e.d) begin
        errors++;
        $display("FAIL areset_rerun sb got idx=%0d desc=%h exp idx=%0d desc=%h", o.idx, o.d, e.idx, e.d);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    set_desc(0, 32'h0000_1000, 32'h0000_2000, 32'h0000_0100);
    set_desc(1, 32'h0000_3040, 32'h0000_8080, 32'h0000_0040);
    set_desc(2, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000);
    set_desc(3, 32'hA000_0000, 32'hB000_0FC0, 32'h0001_0000);
    test_reset();
    test_single();
    test_two_slots();
    test_done_order();
    test_invalid();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
